// File: rtl/mul_div_if.sv
// Operand/result bus between the execute stage and the MUL/DIV unit.
// The execute stage is the master: it issues ops and reads hi/lo after done.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output opA, opB, op, start, input busy, done, hi, lo);
    modport slave  (input opA, opB, op, start, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// MUL/DIV unit: pipelined signed/unsigned multiply, radix-2 restoring divide,
// and MTHI/MTLO writes into the architectural HI/LO registers.
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic      clk,
    input  logic      resetn,
    mul_div_if.slave  bus
);
    localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_INIT, S_DIV_ITER, S_DIV_FIX, S_MOVE
    } state_e;

    state_e                            state_q;
    logic [CW-1:0]                     cnt_q;
    logic                              op0_q;
    logic [WIDTH-1:0]                  a_q, b_q;
    logic [WIDTH-1:0]                  rem_q, quo_q;
    logic                              div0_q, ovf_q, negq_q, negr_q;
    logic [WIDTH-1:0]                  hi_q, lo_q;
    logic                              busy_q, done_q;
    logic [MUL_STAGES-1:0][2*WIDTH-1:0] mul_pipe_q;

    // Operands widened by one bit so MULTU and MULT share one signed multiplier;
    // only the low 2*WIDTH product bits are architecturally visible.
    logic signed [WIDTH:0]     mul_a, mul_b;
    logic signed [2*WIDTH-1:0] prod;

    assign mul_a = {bus.op[0] & bus.opA[WIDTH-1], bus.opA};
    assign mul_b = {bus.op[0] & bus.opB[WIDTH-1], bus.opB};
    assign prod  = mul_a * mul_b;

    // Stage 0 captures the product of whatever is on the bus; the accept edge
    // lines up with the counter so the tail stage holds the started op's product.
    always_ff @(posedge clk) begin
        mul_pipe_q[0] <= prod;
        for (int i = 1; i < MUL_STAGES; i++)
            mul_pipe_q[i] <= mul_pipe_q[i-1];
    end

    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign a_neg  = op0_q & a_q[WIDTH-1];
    assign b_neg  = op0_q & b_q[WIDTH-1];
    assign a_mag  = a_neg ? -a_q : a_q;
    assign b_mag  = b_neg ? -b_q : b_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op0_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.opA;
                        b_q   <= bus.opB;
                        op0_q <= bus.op[0];
                        cnt_q <= '0;
                        case (bus.op)
                            3'd0, 3'd1: begin state_q <= S_MUL;      busy_q <= 1'b1; end
                            3'd2, 3'd3: begin state_q <= S_DIV_INIT; busy_q <= 1'b1; end
                            3'd4, 3'd5: begin state_q <= S_MOVE;     busy_q <= 1'b1; end
                            default:    state_q <= S_IDLE;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        {hi_q, lo_q} <= mul_pipe_q[MUL_STAGES-1];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV_INIT: begin
                    b_q     <= b_mag;
                    quo_q   <= a_mag;
                    rem_q   <= '0;
                    div0_q  <= (b_q == '0);
                    ovf_q   <= op0_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
                    negq_q  <= a_neg ^ b_neg;
                    negr_q  <= a_neg;
                    cnt_q   <= '0;
                    state_q <= S_DIV_ITER;
                end
                S_DIV_ITER: begin
                    if (diff[WIDTH]) begin
                        rem_q <= rem_sh[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q <= diff[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DIV_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV_FIX: begin
                    // Special cases ride the full iteration so latency stays data-independent.
                    if (div0_q) begin
                        lo_q <= '1;
                        hi_q <= a_q;
                    end else if (ovf_q) begin
                        lo_q <= a_q;
                        hi_q <= '0;
                    end else begin
                        lo_q <= negq_q ? -quo_q : quo_q;
                        hi_q <= negr_q ? -rem_q : rem_q;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_MOVE: begin
                    if (op0_q) lo_q <= a_q;
                    else       hi_q <= a_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
